// File: rtl/riscv_ifq_pkg.sv
// Shared constants for the instruction fetch queue: PC step, alignment, reset PC.
package riscv_ifq_pkg;

  // Bytes per instruction word; also the sequential PC increment.
  localparam int ILEN_BYTES = 4;

  // Low address bits that must be zero for an aligned instruction fetch.
  localparam int ALIGN_LSBS = 2;

  // Default first fetch address after reset.
  localparam int unsigned RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/riscv_fifo.sv
// Synchronous FIFO with flush. Storage is not reset; only pointers and count are.
module riscv_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush empties the queue in one edge.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage write.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/riscv_ifq.sv
// Instruction fetch queue: issues sequential word fetches, tracks in-flight
// requests, buffers returned words with their PCs and drops stale responses
// after a redirect. Optional zero-latency bypass: RISCV_IFQ_BYPASS_EN.
module riscv_ifq
  import riscv_ifq_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready
);

  localparam int              CW         = $clog2(DEPTH) + 1;
  localparam logic [CW:0]     DEPTH_C    = (CW + 1)'(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(ILEN_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'((1 << ALIGN_LSBS) - 1);

  logic [XLEN-1:0]   fetch_pc;
  logic [XLEN-1:0]   resp_pc;
  logic [XLEN-1:0]   target_pc;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     discard;
  logic [CW-1:0]     occupancy;
  logic              credit;
  logic              grant;
  logic              resp_keep;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [2*XLEN-1:0] fifo_rdata;

  assign target_pc = redirect_pc & ALIGN_MASK;
  // In-flight plus buffered words never exceed DEPTH, so a full FIFO cannot overflow.
  assign credit    = ({1'b0, outstanding} + {1'b0, occupancy}) < DEPTH_C;
  assign imem_req  = credit && !redirect && !rst;
  assign imem_addr = fetch_pc;
  assign grant     = imem_req && imem_gnt;
  // A response is kept only when no stale responses remain and no redirect kills it.
  assign resp_keep = imem_rvalid && (discard == '0) && !redirect;

  // Consumer-side view and FIFO push/pop steering.
  always_comb begin
    fifo_pop = !fifo_empty && inst_ready && !redirect;
`ifdef RISCV_IFQ_BYPASS_EN
    if (fifo_empty && resp_keep) begin
      inst_valid = 1'b1;
      inst       = imem_rdata;
      inst_pc    = resp_pc;
      fifo_push  = !inst_ready;
    end else begin
      inst_valid = !fifo_empty;
      inst       = fifo_rdata[XLEN-1:0];
      inst_pc    = fifo_rdata[2*XLEN-1:XLEN];
      fifo_push  = resp_keep;
    end
`else
    inst_valid = !fifo_empty;
    inst       = fifo_rdata[XLEN-1:0];
    inst_pc    = fifo_rdata[2*XLEN-1:XLEN];
    fifo_push  = resp_keep;
`endif
  end

  // PC registers and in-flight / stale-response counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding + CW'(grant) - CW'(imem_rvalid);
      if (redirect) begin
        fetch_pc <= target_pc;
        resp_pc  <= target_pc;
        // Everything still in flight is stale; a same-cycle response is dropped now.
        discard  <= outstanding - CW'(imem_rvalid);
      end else begin
        if (grant)     fetch_pc <= fetch_pc + PC_STEP;
        if (resp_keep) resp_pc  <= resp_pc + PC_STEP;
        if (imem_rvalid && (discard != '0)) discard <= discard - CW'(1);
      end
    end
  end

  riscv_fifo #(
    .WIDTH (2 * XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect),
    .push  (fifo_push),
    .wdata ({resp_pc, imem_rdata}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (occupancy)
  );

`ifndef SYNTHESIS
  // Protocol checks: responses only for granted requests, never a push into a full FIFO.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(imem_rvalid && (outstanding == '0)));
      assert (!(fifo_push && fifo_full));
    end
  end
`endif

endmodule

// File: tb/tb_riscv_ifq.sv
// Randomized bench for riscv_ifq against an epoch-tagged memory/consumer model.
module tb_riscv_ifq;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            inst_valid;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic            inst_ready;

  always #5 clk = ~clk;

  riscv_ifq #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready)
  );

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  // Model state: requests granted but not yet answered, words buffered for the
  // consumer, next PC the consumer must see, next PC that must be fetched.
  req_t        pend[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc      = 0;
  int          epoch    = 0;
  int          buffered = 0;
  logic [31:0] fetch_exp;
  logic [31:0] head_exp;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic do_reset(input int n);
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    inst_ready  = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check_val("rst_imem_req", {31'b0, imem_req}, 32'h0);
      check_val("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
      check_val("rst_imem_addr", imem_addr, 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    pend.delete();
    buffered  = 0;
    epoch++;
    fetch_exp = 32'h0;
    head_exp  = 32'h0;
  endtask

  // One cycle per iteration: drive after the falling edge, check, then advance the model at the rising edge.
  task automatic run_cycles(input int n, input int p_gnt, input int p_rv, input int p_rdy,
                            input int max_lat, input int p_redir);
    for (int i = 0; i < n; i++) begin
      logic        rv;
      logic        kept;
      logic        exp_req;
      logic        exp_valid;
      logic        hs;
      logic        gnt;
      logic [31:0] tgt;
      int          sel;
      rv = (pend.size() > 0) && (pend[0].due <= cyc) && ($urandom_range(0, 99) < p_rv);
      imem_rvalid = rv;
      imem_rdata  = rv ? mem_word(pend[0].addr) : $urandom;
      imem_gnt    = ($urandom_range(0, 99) < p_gnt);
      inst_ready  = ($urandom_range(0, 99) < p_rdy);
      redirect    = ($urandom_range(0, 999) < p_redir);
      sel = $urandom_range(0, 3);
      if (sel == 0)      tgt = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      else if (sel == 1) tgt = 32'h0000_0103;
      else               tgt = $urandom;
      redirect_pc = tgt;
      #1;
      exp_req   = ((pend.size() + buffered) < DEPTH) && !redirect;
      kept      = rv && (pend[0].epoch == epoch) && !redirect;
      exp_valid = (buffered > 0);
`ifdef RISCV_IFQ_BYPASS_EN
      if (buffered == 0 && kept) exp_valid = 1'b1;
`endif
      check_val("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
      check_val("imem_addr", imem_addr, fetch_exp);
      check_val("inst_valid", {31'b0, inst_valid}, {31'b0, exp_valid});
      if (exp_valid) begin
        check_val("inst_pc", inst_pc, head_exp);
        check_val("inst", inst, mem_word(head_exp));
      end
      hs  = exp_valid && inst_ready && !redirect;
      gnt = exp_req && imem_gnt;
      @(posedge clk);
      if (redirect) begin
        if (rv) pend.delete(0);
        buffered  = 0;
        epoch++;
        fetch_exp = redirect_pc & 32'hFFFF_FFFC;
        head_exp  = redirect_pc & 32'hFFFF_FFFC;
      end else begin
        if (rv) begin
          pend.delete(0);
          if (kept) buffered++;
        end
        if (hs) begin
          buffered--;
          head_exp = head_exp + 32'd4;
        end
        if (gnt) begin
          req_t r;
          r.addr  = fetch_exp;
          r.epoch = epoch;
          r.due   = cyc + $urandom_range(1, max_lat);
          pend.push_back(r);
          fetch_exp = fetch_exp + 32'd4;
        end
      end
      cyc++;
      @(negedge clk);
    end
  endtask

  initial begin
    do_reset(3);
    // Streaming with a 1-cycle memory and an always-ready consumer.
    run_cycles(40, 100, 100, 100, 1, 0);
    // Stalled consumer fills the queue, then drains.
    run_cycles(20, 100, 100, 0, 1, 0);
    run_cycles(1, 100, 100, 100, 1, 0);
    run_cycles(10, 100, 100, 0, 1, 0);
    run_cycles(20, 100, 100, 100, 1, 0);
    // Slow memory with in-flight requests and occasional redirects.
    run_cycles(600, 70, 60, 60, 4, 40);
    // Heavy redirect traffic including wrap-around targets.
    run_cycles(600, 90, 90, 80, 2, 120);
    // Reset in the middle of traffic.
    do_reset(2);
    run_cycles(800, 60, 80, 50, 3, 50);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
